// File: rtl/fazyrv_seq_pkg.sv
// Shared types and constants for the FazyRV control sequencer.
// The state enum, fault-cause codes and CONF selector strings live here.
package fazyrv_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IFETCH,
        S_DECODE,
        S_ICYC1,
        S_ICYC2,
        S_SHIFT,
        S_ACK,
        S_FAULT
    } seq_state_e;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_IMEM_ERR = 2'b01;
    localparam logic [1:0] FC_IMEM_TO  = 2'b10;
    localparam logic [1:0] FC_DMEM     = 2'b11;

    localparam logic [23:0] CONF_MIN = "MIN";
    localparam logic [23:0] CONF_CSR = "CSR";

endpackage

// File: rtl/fazyrv_bus_wdog.sv
// Bus wait watchdog: counts cycles spent waiting for an ack and flags a
// timeout on the last permitted wait cycle. MEM_TIMEOUT=0 disables it.
module fazyrv_bus_wdog #(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic clk_i,
    input  logic rst_in,
    input  logic clr_i,
    input  logic wait_i,
    output logic timeout_o
);

    localparam bit          ENABLED = (MEM_TIMEOUT != 0);
    localparam logic [7:0]  LIMIT   = ENABLED ? 8'(MEM_TIMEOUT - 1) : 8'd0;

    logic [7:0] cnt_r;

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            cnt_r <= '0;
        end else if (clr_i) begin
            cnt_r <= '0;
        end else if (wait_i && (cnt_r != '1)) begin
            cnt_r <= cnt_r + 8'd1;
        end
    end

    assign timeout_o = ENABLED && wait_i && (cnt_r == LIMIT);

endmodule

// File: rtl/fazyrv.sv
// Control sequencer for the bit-serial FazyRV core: walks each instruction
// through fetch, decode latency, serial passes, shift and memory phases.
module fazyrv_seq
    import fazyrv_seq_pkg::*;
#(
    parameter int unsigned BWIDTH           = 2,
    parameter int unsigned REG_WIDTH        = 32,
    parameter int unsigned CYCLES_PER_INSTR = REG_WIDTH / BWIDTH,
    parameter int unsigned RF_RD_LAT        = 1,
    parameter int unsigned RF_IS_RAM        = 0,
    parameter logic [23:0] CONF             = "CSR",
    parameter int unsigned MEM_TIMEOUT      = 0,
    localparam int unsigned CW = (CYCLES_PER_INSTR > 1) ? $clog2(CYCLES_PER_INSTR) : 1
) (
    input  logic          clk_i,
    input  logic          rst_in,
    input  logic          abort_i,
    input  logic          pc_noinc_i,
    input  logic          any_jmp_i,
    input  logic          any_br_i,
    input  logic          any_ld_i,
    input  logic          any_st_i,
    input  logic          any_shft_i,
    input  logic          any_slt_i,
    input  logic          any_csr_i,
    input  logic          shft_done_i,
    input  logic          imem_ack_i,
    input  logic          imem_err_i,
    input  logic          dmem_ack_i,
    input  logic          dmem_err_i,
    output logic          imem_stb_o,
    output logic          dmem_stb_o,
    output logic          rf_ram_rstb_o,
    output logic          rf_ram_wstb_o,
    output logic          lsb_o,
    output logic          msb_o,
    output logic          pc_inc_o,
    output logic          cyc_ack_o,
    output logic          cyc_two_o,
    output logic          cyc_shft_o,
    output logic          cyc_two_shift_next_o,
    output logic          hlt_regs_o,
    output logic          hlt_spm_a_o,
    output logic          hlt_imm_o,
    output logic [CW-1:0] icyc_o,
    output logic          fault_o,
    output logic [1:0]    fault_cause_o
);

    // Counter is at least 2 bits wide so it can also count decode latency.
    localparam int unsigned NW         = (CW < 2) ? 2 : CW;
    localparam bit          FULL_CTRL  = (CONF != CONF_MIN);
    localparam bit          CSR_WR     = (CONF == CONF_CSR);
    localparam bit          RAM        = (RF_IS_RAM != 0);
    localparam logic [NW-1:0] LAST_CYC = NW'(CYCLES_PER_INSTR - 1);
    localparam logic [NW-1:0] LAST_DEC = NW'(RF_RD_LAT - 1);

    seq_state_e    state_r, state_nxt;
    logic [NW-1:0] cyc_r, cyc_nxt;
    logic [1:0]    cause_r, cause_nxt;
    logic          lsb_r;
    logic          msb;
    logic          abort;
    logic          timeout;
    logic          wd_clr;
    logic          wd_wait;
    logic          last_cyc;
    logic          late_inc;

    assign abort    = abort_i & FULL_CTRL;
    assign last_cyc = (cyc_r == LAST_CYC);
    assign late_inc = any_br_i | any_ld_i | any_st_i;

    always_comb begin
        state_nxt = state_r;
        cause_nxt = cause_r;
        msb       = 1'b0;
        unique case (state_r)
            S_IDLE: begin
                msb       = 1'b1;
                state_nxt = S_IFETCH;
            end
            S_IFETCH: begin
                msb = 1'b1;
                if (imem_ack_i) begin
                    state_nxt = S_DECODE;
                end else if (imem_err_i) begin
                    state_nxt = S_FAULT;
                    cause_nxt = FC_IMEM_ERR;
                end else if (timeout) begin
                    state_nxt = S_FAULT;
                    cause_nxt = FC_IMEM_TO;
                end
            end
            S_DECODE: begin
                msb = 1'b1;
                if (cyc_r == LAST_DEC) state_nxt = S_ICYC1;
            end
            S_ICYC1: begin
                if (last_cyc) begin
                    msb = 1'b1;
                    if (abort)                                            state_nxt = S_IFETCH;
                    else if (any_shft_i)                                  state_nxt = shft_done_i ? S_ICYC2 : S_SHIFT;
                    else if (any_ld_i)                                    state_nxt = S_ACK;
                    else if (any_jmp_i | any_br_i | any_st_i | any_slt_i | any_csr_i) state_nxt = S_ICYC2;
                    else                                                  state_nxt = S_IFETCH;
                end
            end
            S_ICYC2: begin
                if (last_cyc) begin
                    msb       = 1'b1;
                    state_nxt = any_st_i ? S_ACK : S_IFETCH;
                end
            end
            S_SHIFT: begin
                if (shft_done_i) begin
                    msb       = 1'b1;
                    state_nxt = S_ICYC2;
                end
            end
            S_ACK: begin
                msb = dmem_ack_i;
                if (abort) begin
                    state_nxt = S_IFETCH;
                end else if (dmem_ack_i) begin
                    if (any_ld_i) state_nxt = shft_done_i ? S_ICYC2 : S_SHIFT;
                    else          state_nxt = S_IFETCH;
                end else if (dmem_err_i | timeout) begin
                    state_nxt = S_FAULT;
                    cause_nxt = FC_DMEM;
                end
            end
            S_FAULT: begin
                msb       = 1'b1;
                state_nxt = S_IFETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Serial index only advances while staying in a counting state.
    always_comb begin
        cyc_nxt = '0;
        if ((state_nxt == state_r) &&
            ((state_r == S_DECODE) || (state_r == S_ICYC1) || (state_r == S_ICYC2)))
            cyc_nxt = cyc_r + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_r <= S_IDLE;
            cyc_r   <= '0;
            lsb_r   <= 1'b0;
            cause_r <= FC_NONE;
        end else begin
            state_r <= state_nxt;
            cyc_r   <= cyc_nxt;
            lsb_r   <= msb;
            cause_r <= cause_nxt;
        end
    end

    assign wd_clr  = (state_nxt != state_r) && ((state_nxt == S_IFETCH) || (state_nxt == S_ACK));
    assign wd_wait = ((state_r == S_IFETCH) && !imem_ack_i) || ((state_r == S_ACK) && !dmem_ack_i);

    fazyrv_bus_wdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wdog (
        .clk_i     (clk_i),
        .rst_in    (rst_in),
        .clr_i     (wd_clr),
        .wait_i    (wd_wait),
        .timeout_o (timeout)
    );

    assign imem_stb_o           = (state_r == S_IFETCH);
    assign dmem_stb_o           = (state_r == S_ACK);
    assign msb_o                = msb;
    assign lsb_o                = lsb_r;
    assign icyc_o               = cyc_r[CW-1:0];
    assign pc_inc_o             = lsb_r & ~(pc_noinc_i & FULL_CTRL) &
                                  (late_inc ? (state_r == S_ICYC2) : (state_r == S_ICYC1));
    assign cyc_ack_o            = (state_r == S_ACK);
    assign cyc_two_o            = (state_r == S_ICYC2);
    assign cyc_shft_o           = (state_r == S_SHIFT);
    assign cyc_two_shift_next_o = (state_nxt == S_ICYC2) || (state_nxt == S_SHIFT);
    assign hlt_regs_o           = ~((state_r == S_ICYC1) || (state_r == S_ICYC2));
    assign hlt_spm_a_o          = ~((state_r == S_ICYC1) & ~(any_shft_i & msb));
    assign hlt_imm_o            = (state_r == S_ICYC1) & any_br_i;
    assign fault_o              = (state_r == S_FAULT);
    assign fault_cause_o        = cause_r;
    assign rf_ram_rstb_o        = RAM && (state_r == S_DECODE) && (cyc_r < NW'(2));
    assign rf_ram_wstb_o        = RAM && ((state_r == S_IFETCH) ||
                                  (CSR_WR && (state_r == S_ICYC2) && lsb_r && any_csr_i));

endmodule

// File: tb/tb_fazyrv_seq.sv
// Scoreboard bench for fazyrv_seq: instructions are planned as phase lists,
// expected per-cycle outputs are queued and a negedge monitor compares them.
module tb_fazyrv_seq;

    localparam int CPI = 16;
    localparam int LAT = 3;
    localparam int TO  = 8;

    logic clk_i = 1'b0;
    logic rst_in = 1'b0;
    logic abort_i = 0, pc_noinc_i = 0;
    logic any_jmp_i = 0, any_br_i = 0, any_ld_i = 0, any_st_i = 0;
    logic any_shft_i = 0, any_slt_i = 0, any_csr_i = 0;
    logic shft_done_i = 0, imem_ack_i = 0, imem_err_i = 0, dmem_ack_i = 0, dmem_err_i = 0;
    logic imem_stb_o, dmem_stb_o, rf_ram_rstb_o, rf_ram_wstb_o, lsb_o, msb_o, pc_inc_o;
    logic cyc_ack_o, cyc_two_o, cyc_shft_o, cyc_two_shift_next_o;
    logic hlt_regs_o, hlt_spm_a_o, hlt_imm_o, fault_o;
    logic [3:0] icyc_o;
    logic [1:0] fault_cause_o;

    fazyrv_seq #(
        .BWIDTH(2), .REG_WIDTH(32), .RF_RD_LAT(LAT), .RF_IS_RAM(1),
        .CONF("CSR"), .MEM_TIMEOUT(TO)
    ) dut (
        .clk_i(clk_i), .rst_in(rst_in), .abort_i(abort_i), .pc_noinc_i(pc_noinc_i),
        .any_jmp_i(any_jmp_i), .any_br_i(any_br_i), .any_ld_i(any_ld_i), .any_st_i(any_st_i),
        .any_shft_i(any_shft_i), .any_slt_i(any_slt_i), .any_csr_i(any_csr_i),
        .shft_done_i(shft_done_i), .imem_ack_i(imem_ack_i), .imem_err_i(imem_err_i),
        .dmem_ack_i(dmem_ack_i), .dmem_err_i(dmem_err_i),
        .imem_stb_o(imem_stb_o), .dmem_stb_o(dmem_stb_o),
        .rf_ram_rstb_o(rf_ram_rstb_o), .rf_ram_wstb_o(rf_ram_wstb_o),
        .lsb_o(lsb_o), .msb_o(msb_o), .pc_inc_o(pc_inc_o),
        .cyc_ack_o(cyc_ack_o), .cyc_two_o(cyc_two_o), .cyc_shft_o(cyc_shft_o),
        .cyc_two_shift_next_o(cyc_two_shift_next_o),
        .hlt_regs_o(hlt_regs_o), .hlt_spm_a_o(hlt_spm_a_o), .hlt_imm_o(hlt_imm_o),
        .icyc_o(icyc_o), .fault_o(fault_o), .fault_cause_o(fault_cause_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic imem_stb, dmem_stb, rstb, wstb, lsb, msb, pc_inc;
        logic cack, ctwo, cshft, tsn, hregs, hspm, himm;
        logic [3:0] icyc;
        logic fault;
        logic [1:0] cause;
    } obs_t;

    typedef enum int {P_IDLE, P_FETCH, P_DEC, P_C1, P_C2, P_SH, P_ACK, P_FLT} ph_e;
    typedef struct {
        ph_e ph; int idx;
        bit iack, ierr, dack, derr, sdone, abrt;
        bit [1:0] cause;
    } slot_t;

    obs_t  exp_q[$];
    string tag_q[$];
    slot_t plan[$];
    int n_checks = 0, n_fail = 0, pushed = 0, popped = 0;

    // instruction knobs: class 0 alu,1 jmp,2 br,3 ld,4 st,5 shift,6 slt,7 csr
    int cur_cls, fack, ferr, mdly, merr, mab, sw;
    bit cur_noinc, mboth, ab1, prev_msb;
    bit [1:0] cause_m;

    function automatic obs_t sample();
        obs_t a;
        a.imem_stb = imem_stb_o; a.dmem_stb = dmem_stb_o; a.rstb = rf_ram_rstb_o;
        a.wstb = rf_ram_wstb_o; a.lsb = lsb_o; a.msb = msb_o; a.pc_inc = pc_inc_o;
        a.cack = cyc_ack_o; a.ctwo = cyc_two_o; a.cshft = cyc_shft_o;
        a.tsn = cyc_two_shift_next_o; a.hregs = hlt_regs_o; a.hspm = hlt_spm_a_o;
        a.himm = hlt_imm_o; a.icyc = icyc_o; a.fault = fault_o; a.cause = fault_cause_o;
        return a;
    endfunction

    function automatic string ph_name(ph_e p);
        case (p)
            P_IDLE: return "idle"; P_FETCH: return "fetch"; P_DEC: return "decode";
            P_C1: return "icyc1"; P_C2: return "icyc2"; P_SH: return "shift";
            P_ACK: return "ack"; default: return "fault";
        endcase
    endfunction

    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            obs_t e, a;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = sample();
            popped++;
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: outputs got %h expected %h", t, a, e);
            end
        end
    end

    function automatic slot_t mk(ph_e ph, int idx);
        slot_t s;
        s.ph = ph; s.idx = idx; s.iack = 0; s.ierr = 0; s.dack = 0; s.derr = 0;
        s.sdone = 0; s.abrt = 0; s.cause = 2'b00;
        return s;
    endfunction

    task automatic add_fault(input bit [1:0] c);
        slot_t s;
        s = mk(P_FLT, 0);
        s.cause = c;
        plan.push_back(s);
    endtask

    task automatic add_shift();
        for (int j = 0; j < sw; j++) begin
            slot_t s;
            s = mk(P_SH, j);
            s.sdone = (j == sw - 1);
            plan.push_back(s);
        end
    endtask

    task automatic add_c2();
        for (int i = 0; i < CPI; i++) plan.push_back(mk(P_C2, i));
    endtask

    task automatic add_ack(output bit ok);
        ok = 0;
        for (int i = 0; i < 64; i++) begin
            slot_t s;
            s = mk(P_ACK, i);
            if (i == mab) begin
                s.abrt = 1; s.dack = (i == mdly);
                plan.push_back(s);
                return;
            end
            if (i == mdly) begin
                s.dack = 1; s.derr = mboth; s.sdone = (cur_cls == 3) && (sw == 0);
                plan.push_back(s);
                if (cur_cls == 3) add_shift();
                ok = 1;
                return;
            end
            if (i == merr) begin
                s.derr = 1;
                plan.push_back(s);
                add_fault(2'b11);
                return;
            end
            plan.push_back(s);
            if (i == TO - 1) begin
                add_fault(2'b11);
                return;
            end
        end
    endtask

    task automatic build_instr();
        bit ok;
        plan.delete();
        for (int i = 0; i < 64; i++) begin
            slot_t s;
            s = mk(P_FETCH, i);
            if (i == fack) begin
                s.iack = 1; s.ierr = (i == ferr);
                plan.push_back(s);
                break;
            end
            if (i == ferr) begin
                s.ierr = 1;
                plan.push_back(s);
                add_fault(2'b01);
                return;
            end
            plan.push_back(s);
            if (i == TO - 1) begin
                add_fault(2'b10);
                return;
            end
        end
        for (int i = 0; i < LAT; i++) plan.push_back(mk(P_DEC, i));
        for (int i = 0; i < CPI; i++) begin
            slot_t s;
            s = mk(P_C1, i);
            if (i == CPI - 1) begin
                s.abrt = ab1;
                s.sdone = (cur_cls == 5) && (sw == 0);
            end
            plan.push_back(s);
        end
        if (ab1) return;
        if (cur_cls == 5) begin
            add_shift(); add_c2();
        end else if (cur_cls == 3) begin
            add_ack(ok);
            if (ok) add_c2();
        end else if (cur_cls != 0) begin
            add_c2();
            if (cur_cls == 4) add_ack(ok);
        end
    endtask

    task automatic emit(input int limit);
        for (int k = 0; k < plan.size() && k < limit; k++) begin
            slot_t s;
            ph_e np;
            obs_t e;
            bit br, ld, st, sh, csr, c1, c2;
            s  = plan[k];
            np = (k + 1 < plan.size()) ? plan[k+1].ph : P_FETCH;
            br = (cur_cls == 2); ld = (cur_cls == 3); st = (cur_cls == 4);
            sh = (cur_cls == 5); csr = (cur_cls == 7);
            any_jmp_i = (cur_cls == 1); any_br_i = br; any_ld_i = ld; any_st_i = st;
            any_shft_i = sh; any_slt_i = (cur_cls == 6); any_csr_i = csr;
            pc_noinc_i = cur_noinc;
            imem_ack_i = s.iack; imem_err_i = s.ierr; dmem_ack_i = s.dack;
            dmem_err_i = s.derr; shft_done_i = s.sdone; abort_i = s.abrt;
            c1 = (s.ph == P_C1); c2 = (s.ph == P_C2);
            if (s.ph == P_FLT) cause_m = s.cause;
            e = '0;
            case (s.ph)
                P_C1, P_C2: e.msb = (s.idx == CPI - 1);
                P_SH:       e.msb = s.sdone;
                P_ACK:      e.msb = s.dack;
                default:    e.msb = 1'b1;
            endcase
            e.lsb      = prev_msb;
            e.imem_stb = (s.ph == P_FETCH);
            e.dmem_stb = (s.ph == P_ACK);
            e.rstb     = (s.ph == P_DEC) && (s.idx < 2);
            e.wstb     = (s.ph == P_FETCH) || (c2 && e.lsb && csr);
            e.pc_inc   = e.lsb && !cur_noinc && ((br || ld || st) ? c2 : c1);
            e.cack     = (s.ph == P_ACK);
            e.ctwo     = c2;
            e.cshft    = (s.ph == P_SH);
            e.tsn      = (np == P_C2) || (np == P_SH);
            e.hregs    = !(c1 || c2);
            e.hspm     = !(c1 && !(sh && e.msb));
            e.himm     = c1 && br;
            e.icyc     = (c1 || c2 || s.ph == P_DEC) ? 4'(s.idx) : 4'd0;
            e.fault    = (s.ph == P_FLT);
            e.cause    = cause_m;
            exp_q.push_back(e);
            tag_q.push_back($sformatf("%s%0d_cls%0d", ph_name(s.ph), s.idx, cur_cls));
            pushed++;
            @(posedge clk_i);
            #1;
            prev_msb = e.msb;
        end
    endtask

    task automatic default_knobs(input int cls);
        cur_cls = cls; cur_noinc = 0; fack = 0; ferr = -1;
        mdly = 0; merr = -1; mboth = 0; mab = -1; sw = 0; ab1 = 0;
    endtask

    task automatic rand_knobs();
        int r;
        default_knobs($urandom_range(0, 7));
        cur_noinc = ($urandom_range(0, 3) == 0);
        r = $urandom_range(0, 9);
        if (r < 6)      fack = $urandom_range(0, 3);
        else if (r < 8) begin ferr = $urandom_range(0, 3); fack = ferr + $urandom_range(0, 1); end
        else            fack = 100;
        mdly = $urandom_range(0, 4);
        r = $urandom_range(0, 11);
        if (r == 7)       begin merr = $urandom_range(0, 3); mdly = 100; end
        else if (r == 8)  mdly = 100;
        else if (r == 9)  mboth = 1;
        else if (r == 10) begin mab = $urandom_range(0, 3); mdly = mab + $urandom_range(0, 1); end
        sw  = $urandom_range(0, 5);
        ab1 = ($urandom_range(0, 15) == 0);
    endtask

    task automatic run_idle();
        plan.delete();
        plan.push_back(mk(P_IDLE, 0));
        cur_cls = 0; cur_noinc = 0;
        emit(1);
    endtask

    initial begin
        obs_t er, ar;
        prev_msb = 0; cause_m = 2'b00;
        repeat (3) @(posedge clk_i);
        #1 rst_in = 1'b1;
        run_idle();
        // directed: alu, store ack@3, load shift 5, fetch timeout, ack+err, abort+ack, csr, br noinc
        default_knobs(0);                           build_instr(); emit(9999);
        default_knobs(4); mdly = 3;                 build_instr(); emit(9999);
        default_knobs(3); sw = 5;                   build_instr(); emit(9999);
        default_knobs(0); fack = 100;               build_instr(); emit(9999);
        default_knobs(3); mdly = 1; mboth = 1;      build_instr(); emit(9999);
        default_knobs(4); mdly = 2; mab = 2;        build_instr(); emit(9999);
        default_knobs(7);                           build_instr(); emit(9999);
        default_knobs(2); cur_noinc = 1;            build_instr(); emit(9999);
        default_knobs(5); sw = 3;                   build_instr(); emit(9999);
        default_knobs(0); ferr = 1; fack = 5;       build_instr(); emit(9999);
        for (int n = 0; n < 150; n++) begin
            rand_knobs(); build_instr(); emit(9999);
        end
        // asynchronous reset in the middle of ICYC1
        default_knobs(4);
        build_instr();
        emit(1 + LAT + 6);
        #2 rst_in = 1'b0;
        #1;
        er = '0; er.msb = 1; er.hregs = 1; er.hspm = 1;
        ar = sample();
        n_checks++;
        if (ar !== er) begin
            n_fail++;
            $display("FAIL async_reset: outputs got %h expected %h", ar, er);
        end
        @(posedge clk_i);
        #1 rst_in = 1'b1;
        prev_msb = 0; cause_m = 2'b00;
        run_idle();
        default_knobs(1); build_instr(); emit(9999);
        repeat (2) @(posedge clk_i);
        n_checks++;
        if (popped != pushed) begin
            n_fail++;
            $display("FAIL drain: checked %0d expected %0d", popped, pushed);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
